// File: rtl/fifo_pkg.sv
// fifo_pkg: types and helpers shared by the synchronous FIFO slice.
//   fifo_mode_e : read-side behaviour (registered read or first-word-fall-through)
//   ptr_w()     : pointer/count width for a given depth (one extra MSB so that
//                 full and empty are distinguishable with wrapping pointers)
package fifo_pkg;

    typedef enum logic {
        FIFO_STD,
        FIFO_FWFT
    } fifo_mode_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// The array has no reset so it maps onto block or distributed RAM.
//   clk     : common clock
//   wr_en   : write strobe; wr_data stored at wr_addr
//   rd_en   : read strobe; mem[rd_addr] captured into rd_data
//   rd_data : holds its value while rd_en is low
// Reading and writing the same address on one edge returns the old contents.
module sdp_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with optional first-word-fall-through output,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky
// overflow/underflow flags.
//   clk, rst_n           : clock, asynchronous active-low reset
//   d_in, wr_en          : write data and request
//   rd_en                : read (STD) or pop (FWFT) request
//   d_out                : read data
//   full, empty          : no free slot / no readable word
//   almost_full          : count >= AF_THRESH
//   almost_empty         : count <= AE_THRESH
//   count                : words held (FWFT: includes the word on d_out)
//   overflow, underflow  : sticky error flags, cleared by clr_err
//   clr_err              : synchronous clear; a same-cycle error wins
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int         DEPTH     = 1024,
    parameter int         WIDTH     = 32,
    parameter fifo_mode_e MODE      = FIFO_STD,
    parameter int         AF_THRESH = DEPTH - 4,
    parameter int         AE_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          d_in,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          d_out,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    // Elaboration-time parameter checks
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 4");
    end
    if (WIDTH < 1 || WIDTH > 72) begin : g_chk_width
        $error("sync_fifo: WIDTH must be in 1..72");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $error("sync_fifo: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    ram_cnt;
    logic [PW-1:0]    count_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic             ram_rd;
    logic             out_valid;
    logic             out_valid_nxt;
    logic             empty_nxt;
    logic             seen_rd;
    logic             ovf_set;
    logic             udf_set;
    logic [WIDTH-1:0] ram_q;

    sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (d_in),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    always_comb begin
        rd_acc        = rd_en && !empty;
        wr_acc        = wr_en && (!full || rd_acc);
        ovf_set       = wr_en && !wr_acc;
        udf_set       = rd_en && empty;
        ram_cnt       = wr_ptr - rd_ptr;

        // In FWFT the RAM's registered read port is the output stage: it is
        // refilled whenever RAM holds a word written on an earlier edge and the
        // stage is either vacant or being popped this edge.
        if (MODE == FIFO_FWFT) begin
            ram_rd = (ram_cnt != '0) && (!out_valid || rd_acc);
        end else begin
            ram_rd = rd_acc;
        end

        out_valid_nxt = out_valid;
        if (ram_rd) begin
            out_valid_nxt = 1'b1;
        end else if (rd_acc) begin
            out_valid_nxt = 1'b0;
        end

        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        if (MODE == FIFO_FWFT) begin
            empty_nxt = !out_valid_nxt;
        end else begin
            empty_nxt = (count_nxt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            out_valid    <= 1'b0;
            seen_rd      <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                seen_rd <= 1'b1;
            end
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= empty_nxt;
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            out_valid    <= out_valid_nxt;
            overflow     <= ovf_set || (overflow && !clr_err);
            underflow    <= udf_set || (underflow && !clr_err);
        end
    end

    // The RAM output register has no reset; d_out reads as zero until the
    // first RAM read after reset has landed.
    always_comb begin
        d_out = seen_rd ? ram_q : '0;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO for the EVR delay-compensation path. It replaces fixed-primitive FIFO instances where both sides share one clock, and uses inferred block or distributed RAM. Beyond a plain FIFO it adds:
- a selectable first-word-fall-through mode
- programmable almost-full and almost-empty thresholds
- an occupancy count
- sticky overflow and underflow error flags.

Parameters:
- DEPTH, 1024: number of storage words; power of two, at least 4.
- WIDTH, 32: data width in bits, 1 to 72.
- MODE, FIFO_STD: fifo_mode_e. FIFO_STD gives a registered read; FIFO_FWFT gives first-word-fall-through.
- AF_THRESH, DEPTH-4: almost_full asserts when count >= AF_THRESH; range 1 to DEPTH.
- AE_THRESH, 4: almost_empty asserts when count <= AE_THRESH; range 0 to DEPTH-1.

Ports:
- clk  in  1  single clock for both sides.
- rst_n  in  1  asynchronous, active-low reset.
- d_in  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read or pop request.
- d_out  out  WIDTH  read data.
- full  out  1  no free slot.
- empty  out  1  no readable word.
- almost_full  out  1  threshold flag.
- almost_empty  out  1  threshold flag.
- count  out  $clog2(DEPTH)+1  words held.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was ignored.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset values: pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, d_out 0, overflow 0, underflow 0.
- Reset asserted mid-operation discards all contents. No RAM clear is required.
- Pointers are $clog2(DEPTH)+1 bits and wrap naturally. The extra MSB distinguishes full from empty.
- A write is accepted when wr_en=1 and (full=0, or a read is accepted in the same cycle).
- A read is accepted when rd_en=1 and empty=0.
- All flags and count are registered and update on the same edge as the accepted operation.
- count is accepted writes minus accepted reads. In FWFT mode it includes the word presented on d_out.
- full = (count == DEPTH). almost_full and almost_empty are derived from the next-state count, so they never lag count.
- Simultaneous write and read, neither empty nor full: both are accepted and count is unchanged.
- Simultaneous write and read when full: both are accepted, count stays at DEPTH, no overflow.
- Simultaneous write and read when empty: the write is accepted, the read is ignored and underflow is set.
- wr_en while full with no accepted read: data is dropped, overflow is set and the FIFO state is unchanged.
- rd_en while empty: underflow is set. In FIFO_STD mode d_out holds its value.
- clr_err clears both error flags. An error event in the same cycle as clr_err takes priority, so the flag ends up 1.
- FIFO_STD:
  - empty = (count == 0).
  - A read accepted at edge N puts the head word on d_out after edge N.
  - d_out holds the last read word until the next accepted read.
- FIFO_FWFT:
  - A two-entry structure: RAM plus an output register with a valid bit. empty = !out_valid.
  - A write into an empty FIFO at edge N gives d_out = word and empty = 0 after edge N+1. For that one cycle count = 1 while empty = 1.
  - rd_en with empty=0 pops at the edge. If RAM holds more data, the next word is on d_out after the same edge, which sustains one pop per cycle.
  - When the FIFO drains, d_out holds the last popped word.
- Throughput: one write and one read per cycle, sustained, in both modes.
- Elaboration check: $error if DEPTH is not a power of two, or if AF_THRESH or AE_THRESH is out of range.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - function ptr_w(depth) returning $clog2(depth)+1.
- Sub-module sdp_ram:
  - parameters DEPTH and WIDTH
  - one write port and one read port with a registered read and a read enable
  - no reset on the array, so it infers block RAM.
- sync_fifo owns pointers, count, flags and the FWFT output stage.

Test Plan (DEPTH=16, WIDTH=8, AF_THRESH=12, AE_THRESH=2):
1. Reset, then write 0x01..0x10 on consecutive cycles -> full=1 after the 16th edge, count=16, almost_full=1 from count=12, almost_empty=0 from count=3. A 17th write of 0xAA -> overflow=1, contents unchanged.
2. FIFO_STD: from the full state of test 1, assert rd_en for 16 cycles -> d_out = 0x01..0x10, each one edge after its read. Then empty=1 and count=0. One extra rd_en -> underflow=1, d_out stays 0x10.
3. FIFO_FWFT: write 0x5A into an empty FIFO at edge N -> d_out=0x5A and empty=0 after N+1. Pop at N+2 -> empty=1 and count=0.
4. Pointer wrap: 40 cycles of simultaneous wr/rd with an incrementing pattern at count=5 -> count stays 5, output order is preserved, no error flags.
5. When full, simultaneous wr 0x77 and rd -> count=16, no overflow, and 0x77 is read last. When empty, simultaneous wr and rd -> count=1, underflow=1.
6. With overflow=1, pulse clr_err -> overflow=0. Then drive rst_n low mid-stream at count=9 -> all outputs return to their reset values asynchronously.
